// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the PE MAC sequencer.
package pe_seq_pkg;

  // Job sequencing states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } pe_seq_state_t;

  localparam int unsigned PE_LAT_MAX  = 4;
  localparam int unsigned DRAIN_CNT_W = 3;

endpackage

// File: rtl/pe_addr_gen.sv
// Operand buffer address generator: loads a base, steps once per read, wraps modulo 2^ADDR_W.
module pe_addr_gen #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q;

  // Base load on job accept, natural-overflow increment per read strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else if (load_i) begin
      addr_q <= base_i;
    end else if (inc_i) begin
      addr_q <= addr_q + ADDR_W'(1);
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/pe_mac_sequencer.sv
// Sequences one MAC PE through dot-product jobs: clear, stream operand pairs, drain, return result.
// Optional busy-cycle counter output perf_cycles enabled by defining PE_SEQ_PERF_EN.
module pe_mac_sequencer
  import pe_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned PE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] cmd_a_base,
  input  logic [ADDR_W-1:0] cmd_b_base,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_a_addr,
  output logic [ADDR_W-1:0] buf_b_addr,
  input  logic [DATA_W-1:0] buf_a_data,
  input  logic [DATA_W-1:0] buf_b_data,
  output logic              pe_clr,
  output logic              pe_en,
  output logic [DATA_W-1:0] pe_a,
  output logic [DATA_W-1:0] pe_b,
  input  logic [DATA_W-1:0] pe_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy
`ifdef PE_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  // Out-of-range latencies are clamped to the legal 1..PE_LAT_MAX window
  localparam int unsigned PE_LAT_C = (PE_LAT < 1) ? 1 :
                                     (PE_LAT > PE_LAT_MAX) ? PE_LAT_MAX : PE_LAT;

  pe_seq_state_t          state_q;
  logic [LEN_W-1:0]       len_cnt_q;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q;
  logic                   rd_vld_q;
  logic                   accept_c;

  assign accept_c = (state_q == IDLE) && cmd_valid;

  // Job FSM with registered handshake, strobe and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_cnt_q   <= '0;
      drain_cnt_q <= '0;
      rd_vld_q    <= 1'b0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      pe_clr      <= 1'b0;
      buf_rd_en   <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
    end else begin
      rd_vld_q <= buf_rd_en;
      pe_clr   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q   <= CLEAR;
            len_cnt_q <= cmd_len;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            pe_clr    <= 1'b1;
          end
        end
        CLEAR: begin
          if (len_cnt_q == '0) begin
            state_q   <= DONE;
            res_data  <= '0;
            res_valid <= 1'b1;
          end else begin
            state_q   <= STREAM;
            len_cnt_q <= len_cnt_q - LEN_W'(1);
            buf_rd_en <= 1'b1;
          end
        end
        STREAM: begin
          if (len_cnt_q == '0) begin
            state_q     <= DRAIN;
            buf_rd_en   <= 1'b0;
            drain_cnt_q <= DRAIN_CNT_W'(PE_LAT_C);
          end else begin
            len_cnt_q <= len_cnt_q - LEN_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt_q == '0) begin
            state_q   <= DONE;
            res_data  <= pe_c;
            res_valid <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q - DRAIN_CNT_W'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            state_q   <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          buf_rd_en <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

  // Read-data stage: operands arrive one cycle after the read strobe
  assign pe_en = rd_vld_q;
  assign pe_a  = rd_vld_q ? buf_a_data : '0;
  assign pe_b  = rd_vld_q ? buf_b_data : '0;

  pe_addr_gen #(.ADDR_W(ADDR_W)) u_addr_a (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept_c),
    .base_i (cmd_a_base),
    .inc_i  (buf_rd_en),
    .addr_o (buf_a_addr)
  );

  pe_addr_gen #(.ADDR_W(ADDR_W)) u_addr_b (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept_c),
    .base_i (cmd_b_base),
    .inc_i  (buf_rd_en),
    .addr_o (buf_b_addr)
  );

`ifdef PE_SEQ_PERF_EN
  // Saturating busy-cycle counter, restarted on each accept and held while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
    end else if (accept_c) begin
      perf_cycles <= '0;
    end else if (busy && (perf_cycles != '1)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Self-checking bench for pe_mac_sequencer with buffer and PE models (PE_LAT=1, C += A*B).
module tb_pe_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_len;
  logic [7:0]  cmd_a_base;
  logic [7:0]  cmd_b_base;
  logic        buf_rd_en;
  logic [7:0]  buf_a_addr;
  logic [7:0]  buf_b_addr;
  logic [31:0] buf_a_data;
  logic [31:0] buf_b_data;
  logic        pe_clr;
  logic        pe_en;
  logic [31:0] pe_a;
  logic [31:0] pe_b;
  logic [31:0] pe_c;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;
`ifdef PE_SEQ_PERF_EN
  logic [31:0] perf_cycles;
`endif

  pe_mac_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .cmd_a_base (cmd_a_base),
    .cmd_b_base (cmd_b_base),
    .buf_rd_en  (buf_rd_en),
    .buf_a_addr (buf_a_addr),
    .buf_b_addr (buf_b_addr),
    .buf_a_data (buf_a_data),
    .buf_b_data (buf_b_data),
    .pe_clr     (pe_clr),
    .pe_en      (pe_en),
    .pe_a       (pe_a),
    .pe_b       (pe_b),
    .pe_c       (pe_c),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy)
`ifdef PE_SEQ_PERF_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_en = 0, n_rd = 0, n_clr = 0, n_rv = 0;
  logic [7:0]  rd_log [64];
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic        pe_preset = 1'b0;
  logic [31:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Operand buffers with one-cycle read latency
  always @(posedge clk) begin
    if (buf_rd_en) begin
      buf_a_data <= mem_a[buf_a_addr];
      buf_b_data <= mem_b[buf_b_addr];
    end
  end

  // PE model: accumulator with one-cycle update latency
  always @(posedge clk) begin
    if (pe_preset)   pe_c <= 32'd99;
    else if (pe_clr) pe_c <= 32'd0;
    else if (pe_en)  pe_c <= pe_c + pe_a * pe_b;
  end

  // Pulse counters and read-address log
  always @(negedge clk) begin
    if (pe_en)     n_en  <= n_en + 1;
    if (pe_clr)    n_clr <= n_clr + 1;
    if (res_valid) n_rv  <= n_rv + 1;
    if (buf_rd_en) begin
      rd_log[n_rd % 64] <= buf_a_addr;
      n_rd <= n_rd + 1;
    end
  end

  function automatic logic [31:0] dot(input logic [7:0] ab, input logic [7:0] bb, input int len);
    logic [31:0] s = 32'd0;
    for (int i = 0; i < len; i++) s = s + mem_a[8'(ab + 8'(i))] * mem_b[8'(bb + 8'(i))];
    return s;
  endfunction

  task automatic wait_valid(output int at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  // Drive one accept cycle at a negedge; returns accept cycle index
  task automatic issue(input logic [7:0] len, input logic [7:0] ab, input logic [7:0] bb, output int t0);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_len    = len;
    cmd_a_base = ab;
    cmd_b_base = bb;
    t0 = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_len = '0; cmd_a_base = '0; cmd_b_base = '0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || pe_en !== 1'b0 ||
        pe_clr !== 1'b0 || buf_rd_en !== 1'b0 || res_data !== 32'd0 || buf_a_addr !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b busy=%b rv=%b en=%b clr=%b rd=%b data=%0d addr=%0h, required rdy=1 rest 0",
               cmd_ready, busy, res_valid, pe_en, pe_clr, buf_rd_en, res_data, buf_a_addr);
    end
  endtask

  task automatic test_basic();
    int t0, at, e0, c0;
    bit ok;
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) begin
      mem_a[8'h10 + i] = 32'(i + 1);
      mem_b[8'h20 + i] = 32'(i + 5);
    end
    e0 = n_en; c0 = n_clr;
    exp_q.push_back(dot(8'h10, 8'h20, 4));
    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = 8'd4; cmd_a_base = 8'h10; cmd_b_base = 8'h20;
    t0 = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (pe_clr !== 1'b1) begin
      errors++; $display("FAIL basic_clr_at_T1: pe_clr=%b required 1", pe_clr);
    end
    wait_valid(at, ok);
    checks++;
    if (!ok || at - t0 != 8) begin
      errors++; $display("FAIL basic_latency: ok=%0d latency=%0d required 8", ok, at - t0);
    end
    exp = exp_q.pop_front();
    checks++;
    if (res_data !== exp || exp !== 32'd70) begin
      errors++; $display("FAIL basic_result: got %0d required %0d (70)", res_data, exp);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || n_en - e0 != 4 || n_clr - c0 != 1) begin
      errors++; $display("FAIL basic_pulses: cmd_ready=%b pe_en=%0d pe_clr=%0d required 1/4/1",
                         cmd_ready, n_en - e0, n_clr - c0);
    end
`ifdef PE_SEQ_PERF_EN
    checks++;
    if (perf_cycles !== 32'd8) begin
      errors++; $display("FAIL perf_cycles: got %0d required 8", perf_cycles);
    end
`endif
  endtask

  task automatic test_zero_len();
    int t0, at, e0, r0;
    bit ok;
    @(negedge clk);
    pe_preset = 1'b1;
    @(negedge clk);
    pe_preset = 1'b0;
    e0 = n_en; r0 = n_rd;
    exp_q.push_back(32'd0);
    issue(8'd0, 8'h40, 8'h50, t0);
    wait_valid(at, ok);
    checks++;
    if (!ok || at - t0 != 2) begin
      errors++; $display("FAIL zero_latency: ok=%0d latency=%0d required 2", ok, at - t0);
    end
    checks++;
    if (res_data !== exp_q.pop_front()) begin
      errors++; $display("FAIL zero_result: got %0d required 0", res_data);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (n_en != e0 || n_rd != r0) begin
      errors++; $display("FAIL zero_no_activity: pe_en=%0d rd_en=%0d required 0/0", n_en - e0, n_rd - r0);
    end
  endtask

  task automatic test_backpressure();
    int t0, at;
    bit ok;
    logic [31:0] held;
    for (int i = 0; i < 3; i++) begin
      mem_a[8'h60 + i] = 32'(3 * i + 2);
      mem_b[8'h70 + i] = 32'(i + 9);
    end
    exp_q.push_back(dot(8'h60, 8'h70, 3));
    res_ready = 1'b0;
    issue(8'd3, 8'h60, 8'h70, t0);
    wait_valid(at, ok);
    held = exp_q.pop_front();
    checks++;
    if (!ok || res_data !== held) begin
      errors++; $display("FAIL bp_result: ok=%0d got %0d required %0d", ok, res_data, held);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (res_data !== held || res_valid !== 1'b1 || cmd_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d]: data=%0d rv=%b rdy=%b required %0d/1/0",
                           k, res_data, res_valid, cmd_ready, held);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release: rdy=%b rv=%b busy=%b required 1/0/0", cmd_ready, res_valid, busy);
    end
  endtask

  task automatic test_addr_wrap();
    int t0, at, r0;
    bit ok;
    logic [7:0] exp_addr;
    for (int i = 0; i < 4; i++) begin
      mem_a[8'(8'hFE + 8'(i))] = 32'(i + 11);
      mem_b[8'(8'h03 + 8'(i))] = 32'(i + 2);
    end
    exp_q.push_back(dot(8'hFE, 8'h03, 4));
    r0 = n_rd;
    issue(8'd4, 8'hFE, 8'h03, t0);
    wait_valid(at, ok);
    checks++;
    if (!ok || res_data !== exp_q.pop_front()) begin
      errors++; $display("FAIL wrap_result: ok=%0d got %0d", ok, res_data);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      exp_addr = 8'(8'hFE + 8'(i));
      checks++;
      if (rd_log[(r0 + i) % 64] !== exp_addr) begin
        errors++; $display("FAIL wrap_addr[%0d]: got %0h required %0h", i, rd_log[(r0 + i) % 64], exp_addr);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0, at, v0;
    bit ok;
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      mem_a[8'h80 + i] = 32'(i + 7);
      mem_b[8'h90 + i] = 32'(2 * i + 1);
    end
    issue(8'd8, 8'h80, 8'h90, t0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || buf_rd_en !== 1'b0) begin
      errors++; $display("FAIL midreset_state: rdy=%b busy=%b rv=%b rd=%b required 1/0/0/0",
                         cmd_ready, busy, res_valid, buf_rd_en);
    end
    v0 = n_rv;
    repeat (6) @(negedge clk);
    checks++;
    if (n_rv != v0) begin
      errors++; $display("FAIL midreset_no_result: res_valid cycles=%0d required 0", n_rv - v0);
    end
    exp_q.push_back(dot(8'h84, 8'h95, 2));
    issue(8'd2, 8'h84, 8'h95, t0);
    wait_valid(at, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || at - t0 != 6 || res_data !== exp) begin
      errors++; $display("FAIL midreset_next_job: ok=%0d lat=%0d got %0d required lat 6 data %0d",
                         ok, at - t0, res_data, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t0, at, c0;
    bit ok;
    int len;
    logic [7:0] ab, bb;
    logic [31:0] exp;
    for (int j = 0; j < 4; j++) begin
      len = $urandom_range(1, 6);
      ab = 8'($urandom);
      bb = 8'($urandom);
      for (int i = 0; i < len; i++) begin
        mem_a[8'(ab + 8'(i))] = $urandom;
        mem_b[8'(bb + 8'(i))] = $urandom;
      end
      exp_q.push_back(dot(ab, bb, len));
      c0 = n_clr;
      issue(8'(len), ab, bb, t0);
      // A request while busy must be ignored
      cmd_valid = 1'b1; cmd_len = 8'd0;
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_valid(at, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || at - t0 != 4 + len || res_data !== exp) begin
        errors++; $display("FAIL b2b[%0d]: ok=%0d lat=%0d got %0h required lat %0d data %0h",
                           j, ok, at - t0, res_data, 4 + len, exp);
      end
      @(negedge clk);
      checks++;
      if (n_clr - c0 != 1) begin
        errors++; $display("FAIL b2b_busy_ignore[%0d]: pe_clr pulses=%0d required 1", j, n_clr - c0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'd0;
      mem_b[i] = 32'd0;
    end
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_addr_wrap();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_empty: %0d entries left required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
